// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: stall/flush/load-use bubbles, EX operand forwarding and hazard detection.
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding; otherwise any RAW dependence stalls.
module id_ex_stage #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [W-1:0]        id_rs_data,
    input  logic [W-1:0]        id_rt_data,
    input  logic [W-1:0]        id_imm,
    input  logic [RW-1:0]       id_rs,
    input  logic [RW-1:0]       id_rt,
    input  logic [RW-1:0]       id_rd,
    input  logic [2:0]          id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_reg_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                exmem_reg_write,
    input  logic [RW-1:0]       exmem_rd,
    input  logic [W-1:0]        exmem_result,
    input  logic                memwb_reg_write,
    input  logic [RW-1:0]       memwb_rd,
    input  logic [W-1:0]        memwb_result,
    output logic                ex_valid,
    output logic signed [W-1:0] alu_a,
    output logic signed [W-1:0] alu_b,
    output logic [2:0]          alu_op,
    output logic [W-1:0]        ex_store_data,
    output logic [RW-1:0]       ex_dest,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                load_use_hazard,
    output logic [15:0]         bubble_cnt
);
    typedef struct packed {
        logic          vld;
        logic [W-1:0]  rs_data;
        logic [W-1:0]  rt_data;
        logic [W-1:0]  imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        logic [2:0]    alu_op;
        logic          alu_src;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } ex_t;

    ex_t                 ex_p1;
    ex_t                 ex_nxt;
    logic [15:0]         bubble_cnt_p1;
    logic signed [W-1:0] rs_fwd;
    logic signed [W-1:0] rt_fwd;
    logic                hazard;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef ID_EX_FORWARD_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign hazard = ex_p1.vld && ex_p1.mem_read && (ex_p1.dest != '0) && id_valid &&
                    ((ex_p1.dest == id_rs) || (ex_p1.dest == id_rt));

    always_comb begin
        rs_fwd = ex_p1.rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_p1.rs))
            rs_fwd = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_p1.rs))
            rs_fwd = memwb_result;

        rt_fwd = ex_p1.rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_p1.rt))
            rt_fwd = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_p1.rt))
            rt_fwd = memwb_result;
    end
`else
    // Without bypass paths, producers in EX or MEM must drain before the consumer enters EX.
    logic ex_raw;
    logic mem_raw;
    logic unused_fwd;
    assign ex_raw  = ex_p1.vld && ex_p1.reg_write && (ex_p1.dest != '0) &&
                     ((ex_p1.dest == id_rs) || (ex_p1.dest == id_rt));
    assign mem_raw = exmem_reg_write && (exmem_rd != '0) &&
                     ((exmem_rd == id_rs) || (exmem_rd == id_rt));
    assign hazard  = id_valid && (ex_raw || mem_raw);
    assign rs_fwd  = ex_p1.rs_data;
    assign rt_fwd  = ex_p1.rt_data;
    assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, ex_p1.rs, ex_p1.rt};
`endif

    // Gated so the hazard reads 0 while reset is held, even from live upstream inputs.
    assign load_use_hazard = rst_n && hazard;

    always_comb begin
        ex_nxt = ex_p1;
        if (flush) begin
            ex_nxt = '0;
        end else if (!stall) begin
            if (hazard || !id_valid) begin
                ex_nxt = '0;
            end else begin
                ex_nxt.vld        = 1'b1;
                ex_nxt.rs_data    = id_rs_data;
                ex_nxt.rt_data    = id_rt_data;
                ex_nxt.imm        = id_imm;
                ex_nxt.rs         = id_rs;
                ex_nxt.rt         = id_rt;
                ex_nxt.dest       = id_reg_dst ? id_rd : id_rt;
                ex_nxt.alu_op     = id_alu_op;
                ex_nxt.alu_src    = id_alu_src;
                ex_nxt.reg_write  = id_reg_write;
                ex_nxt.mem_read   = id_mem_read;
                ex_nxt.mem_write  = id_mem_write;
                ex_nxt.mem_to_reg = id_mem_to_reg;
            end
        end
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_p1         <= '0;
            bubble_cnt_p1 <= '0;
        end else begin
            ex_p1 <= ex_nxt;
            if (!flush && !stall && hazard)
                bubble_cnt_p1 <= sat_inc16(bubble_cnt_p1);
        end
    end

    assign ex_valid      = ex_p1.vld;
    assign alu_a         = rs_fwd;
    assign alu_b         = ex_p1.alu_src ? $signed(ex_p1.imm) : rt_fwd;
    assign alu_op        = ex_p1.alu_op;
    assign ex_store_data = $unsigned(rt_fwd);
    assign ex_dest       = ex_p1.dest;
    assign ex_reg_write  = ex_p1.reg_write;
    assign ex_mem_read   = ex_p1.mem_read;
    assign ex_mem_write  = ex_p1.mem_write;
    assign ex_mem_to_reg = ex_p1.mem_to_reg;
    assign bubble_cnt    = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table with scoreboard queue, plus reset, load-use, stall/flush and saturation sequences.
module tb_id_ex_stage;
    localparam int W  = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [2:0] id_alu_op;
    logic id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic exmem_reg_write, memwb_reg_write;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [W-1:0] exmem_result, memwb_result;
    logic ex_valid;
    logic signed [W-1:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [W-1:0] ex_store_data;
    logic [RW-1:0] ex_dest;
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;
    int exp_bub = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [2:0]  op;
        logic        src, rdst, rw, mr, mw, m2r;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] a_f, b_f, sd_f, a_n, b_n, sd_n;
        logic [4:0]  dest;
    } vec_t;

    typedef struct {
        logic [31:0] a, b, sd;
        logic [4:0]  dest;
        logic [2:0]  op;
        logic        rw, mr, mw, m2r;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_alu_op = '0;
        id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(ex_valid), 32'd0);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_store"}, ex_store_data, 32'd0);
        check({tag, "_op"}, 32'(alu_op), 32'd0);
        check({tag, "_dest"}, 32'(ex_dest), 32'd0);
        check({tag, "_ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
        check({tag, "_hazard"}, 32'(load_use_hazard), 32'd0);
        check({tag, "_bcnt"}, 32'(bubble_cnt), 32'd0);
    endtask

    localparam int NV = 6;
    vec_t v[NV];

    initial begin
        exp_t e;
        //        rs     rt     rd     rs_data      rt_data      imm           op      src  rdst rw   mr   mw   m2r  xw   xrd    xres          ww   wrd    wres          a_f           b_f           sd_f          a_n     b_n           sd_n    dest
        v[0] = '{5'd3,  5'd4,  5'd8,  32'd5,  32'd11, 32'd0,        3'b000, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd3,  32'd100,       1'b1,5'd3,  32'd7,         32'd100,       32'd11,        32'd11,        32'd5,  32'd11,        32'd11, 5'd8};
        v[1] = '{5'd3,  5'd4,  5'd8,  32'd5,  32'd11, 32'd0,        3'b000, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,5'd0,  32'd100,       1'b1,5'd3,  32'd7,         32'd7,         32'd11,        32'd11,        32'd5,  32'd11,        32'd11, 5'd8};
        v[2] = '{5'd1,  5'd6,  5'd0,  32'd20, 32'd1,  32'hFFFFFFFC, 3'b001, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,5'd0,  32'd0,         1'b1,5'd6,  32'd9,         32'd20,        32'hFFFFFFFC,  32'd9,         32'd20, 32'hFFFFFFFC,  32'd1,  5'd6};
        v[3] = '{5'd0,  5'd0,  5'd9,  32'd0,  32'd0,  32'd0,        3'b100, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,5'd0,  32'd55,        1'b1,5'd0,  32'd66,        32'd0,         32'd0,         32'd0,         32'd0,  32'd0,         32'd0,  5'd9};
        v[4] = '{5'd10, 5'd11, 5'd0,  32'd1,  32'd2,  32'd0,        3'b011, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b1,5'd11, 32'h80000000,  1'b1,5'd10, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h80000000,  32'h80000000,  32'd1,  32'd2,         32'd2,  5'd11};
        v[5] = '{5'd12, 5'd13, 5'd0,  32'd3,  32'd4,  32'd0,        3'b010, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,5'd12, 32'd44,        1'b0,5'd12, 32'd55,        32'd3,         32'd4,         32'd4,         32'd3,  32'd4,         32'd4,  5'd13};

        // Reset held while a live instruction and a matching producer sit on the inputs.
        idle();
        id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'd5; id_rd = 5'd8; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'd100;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_valid", 32'(ex_valid), 32'd0);

        // Table-driven captures, forwarding sources applied after the capture edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            idle();
            id_valid = 1'b1;
            id_rs = v[i].rs; id_rt = v[i].rt; id_rd = v[i].rd;
            id_rs_data = v[i].rs_data; id_rt_data = v[i].rt_data; id_imm = v[i].imm;
            id_alu_op = v[i].op; id_alu_src = v[i].src; id_reg_dst = v[i].rdst;
            id_reg_write = v[i].rw; id_mem_read = v[i].mr; id_mem_write = v[i].mw; id_mem_to_reg = v[i].m2r;
`ifdef ID_EX_FORWARD_EN
            e.a = v[i].a_f; e.b = v[i].b_f; e.sd = v[i].sd_f;
`else
            e.a = v[i].a_n; e.b = v[i].b_n; e.sd = v[i].sd_n;
`endif
            e.dest = v[i].dest; e.op = v[i].op;
            e.rw = v[i].rw; e.mr = v[i].mr; e.mw = v[i].mw; e.m2r = v[i].m2r;
            sb.push_back(e);
            @(posedge clk); #1;
            id_valid = 1'b0;
            exmem_reg_write = v[i].xw; exmem_rd = v[i].xrd; exmem_result = v[i].xres;
            memwb_reg_write = v[i].ww; memwb_rd = v[i].wrd; memwb_result = v[i].wres;
            #1;
            if (sb.size() == 0) begin
                check($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
                check($sformatf("v%0d_alu_a", i), alu_a, e.a);
                check($sformatf("v%0d_alu_b", i), alu_b, e.b);
                check($sformatf("v%0d_store", i), ex_store_data, e.sd);
                check($sformatf("v%0d_dest", i), 32'(ex_dest), 32'(e.dest));
                check($sformatf("v%0d_op", i), 32'(alu_op), 32'(e.op));
                check($sformatf("v%0d_ctrl", i), 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                      32'({e.rw, e.mr, e.mw, e.m2r}));
                check($sformatf("v%0d_hazard", i), 32'(load_use_hazard), 32'd0);
            end
        end

        // Load-use: lw r2 followed by a consumer of r2, with one stalled edge first.
        @(negedge clk);
        idle();
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rs_data = 32'd100; id_imm = 32'd8; id_alu_src = 1'b1;
        id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
        @(posedge clk); #1;
        check("lw_mem_read", 32'(ex_mem_read), 32'd1);
        check("lw_dest", 32'(ex_dest), 32'd2);
        @(negedge clk);
        idle();
        id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd2; id_rd = 5'd7; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        id_rs_data = 32'd40; id_rt_data = 32'h33;
        stall = 1'b1;
        #1 check("lu_hazard", 32'(load_use_hazard), 32'd1);
        @(posedge clk); #1;
        check("lu_stall_hold_valid", 32'(ex_valid), 32'd1);
        check("lu_stall_hold_dest", 32'(ex_dest), 32'd2);
        check("lu_stall_bcnt", 32'(bubble_cnt), 32'(exp_bub));
        @(negedge clk);
        stall = 1'b0;
        #1 check("lu_hazard_still", 32'(load_use_hazard), 32'd1);
        @(posedge clk); #1;
        exp_bub++;
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_bcnt", 32'(bubble_cnt), 32'(exp_bub));
        check("lu_hazard_clear", 32'(load_use_hazard), 32'd0);
        @(posedge clk); #1;
        check("lu_capture_valid", 32'(ex_valid), 32'd1);
        check("lu_capture_dest", 32'(ex_dest), 32'd7);
        memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_result = 32'h1234;
        #1;
        check("lu_alu_a", alu_a, 32'd40);
`ifdef ID_EX_FORWARD_EN
        check("lu_alu_b_memwb", alu_b, 32'h1234);
`else
        check("lu_alu_b_regfile", alu_b, 32'h33);
`endif

        // Stall holds for three edges, then stall+flush inserts a bubble.
        @(negedge clk);
        idle();
        id_valid = 1'b1; id_rs = 5'd14; id_rs_data = 32'h55; id_rt = 5'd15; id_rt_data = 32'h66;
        id_rd = 5'd16; id_reg_dst = 1'b1; id_alu_op = 3'b011; id_mem_write = 1'b1;
        @(posedge clk); #1;
        check("sf_capture_a", alu_a, 32'h55);
        @(negedge clk);
        stall = 1'b1; id_rs_data = 32'h99; id_rd = 5'd17; id_alu_op = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", c), 32'(ex_valid), 32'd1);
            check($sformatf("stall%0d_a", c), alu_a, 32'h55);
            check($sformatf("stall%0d_b", c), alu_b, 32'h66);
            check($sformatf("stall%0d_dest", c), 32'(ex_dest), 32'd16);
            check($sformatf("stall%0d_op", c), 32'(alu_op), 32'd3);
            check($sformatf("stall%0d_mw", c), 32'(ex_mem_write), 32'd1);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_op", 32'(alu_op), 32'd0);
        check("flush_mw", 32'(ex_mem_write), 32'd0);
        check("flush_dest", 32'(ex_dest), 32'd0);
        check("flush_a", alu_a, 32'd0);
        check("flush_bcnt", 32'(bubble_cnt), 32'(exp_bub));
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        idle();

        // Asynchronous reset between edges discards the captured instruction and the bubble count.
        @(negedge clk);
        id_valid = 1'b1; id_rs = 5'd18; id_rs_data = 32'h77; id_rd = 5'd19; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        @(posedge clk); #1;
        check("mid_capture_valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 1'b0;
        exp_bub = 0;
        #1;
        check("async_valid", 32'(ex_valid), 32'd0);
        check("async_a", alu_a, 32'd0);
        check("async_dest", 32'(ex_dest), 32'd0);
        check("async_rw", 32'(ex_reg_write), 32'd0);
        check("async_bcnt", 32'(bubble_cnt), 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_valid", 32'(ex_valid), 32'd0);

        // Bubble counter growth and saturation.
        @(negedge clk);
        idle();
`ifdef ID_EX_FORWARD_EN
        id_valid = 1'b1; id_rt = 5'd4; id_mem_read = 1'b1; id_reg_write = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("repeat_lu_bcnt", 32'(bubble_cnt), 32'd3);
        check("repeat_lu_valid", 32'(ex_valid), 32'd0);
`else
        id_valid = 1'b1; id_rs = 5'd4; exmem_reg_write = 1'b1; exmem_rd = 5'd4;
        #1 check("sat_hazard", 32'(load_use_hazard), 32'd1);
        repeat (65534) @(posedge clk);
        #1 check("sat_fffe", 32'(bubble_cnt), 32'hFFFE);
        @(posedge clk); #1;
        check("sat_ffff", 32'(bubble_cnt), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 32'(bubble_cnt), 32'hFFFF);
        check("sat_valid", 32'(ex_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core. It captures decoded operands and control from the decode stage and applies stall, flush and load-use bubble insertion. It resolves EX/MEM and MEM/WB forwarding and drives the signed 32-bit operands and 3-bit opcode straight into the ALU. It also raises the load-use hazard indication back to the fetch/decode stages.

## Interface
Parameters:
- `W`, 32, datapath width.
- `RW`, 5, register-index width.

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `stall`, input, 1, downstream hold; the stage keeps its contents.
- `flush`, input, 1, replace the next stage contents with a bubble.
- `id_valid`, input, 1, the decode slot holds a real instruction.
- `id_rs_data`, `id_rt_data`, input, W, register-file read data.
- `id_imm`, input, W, sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`, input, RW, register indices.
- `id_alu_op`, input, 3, ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, input, 1 each, decode control bits.
- `exmem_reg_write`, input, 1, forwarding source write enable.
- `exmem_rd`, input, RW, forwarding source register index.
- `exmem_result`, input, W, forwarding source data.
- `memwb_reg_write`, input, 1, forwarding source write enable.
- `memwb_rd`, input, RW, forwarding source register index.
- `memwb_result`, input, W, forwarding source data.
- `ex_valid`, output, 1, the EX slot holds a real instruction.
- `alu_a`, `alu_b`, output, W (signed), ALU operands.
- `alu_op`, output, 3, registered opcode.
- `ex_store_data`, output, W, forwarded rt value for stores.
- `ex_dest`, output, RW, destination register: rd if `reg_dst`, else rt.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, output, 1 each, registered control bits.
- `load_use_hazard`, output, 1, upstream must hold PC and IF/ID this cycle.
- `bubble_cnt`, output, 16, saturating count of hazard bubbles.

## Operation
- Stored fields: valid, rs_data, rt_data, imm, rs, rt, dest, alu_op, alu_src, and the four control bits.
- Next-state priority is highest first:
  - `flush`: insert a bubble.
  - `stall`: hold all fields.
  - `load_use_hazard`: insert a bubble.
  - `id_valid`: capture the decode inputs.
  - otherwise: insert a bubble.
- Bubble contents: every stored field is 0. This gives `ex_valid`=0, all control bits 0 and `alu_op`=000.
- Decode inputs are never captured while `stall` is high. `flush` overrides a simultaneous `stall`.
- The destination is computed at capture: `id_reg_dst` ? `id_rd` : `id_rt`.
- Forwarding applies independently to the rs and rt operands. For each operand, in priority order:
  - Take `exmem_result` if `exmem_reg_write`, `exmem_rd`≠0 and `exmem_rd` equals the stored index.
  - Else take `memwb_result` under the same conditions on `memwb_rd`.
  - Else take the stored register data.
  - Register 0 is never forwarded.
- `alu_a` is the forwarded rs value.
- `alu_b` is the stored imm if `alu_src` is set, else the forwarded rt value.
- `ex_store_data` is always the forwarded rt value.
- `load_use_hazard` = `ex_valid` & `ex_mem_read` & `ex_dest`≠0 & `id_valid` & (`ex_dest`==`id_rs` | `ex_dest`==`id_rt`).
- `bubble_cnt` increments by 1 on each clock edge where a hazard bubble is inserted (`!flush` & `!stall` & `load_use_hazard`). It saturates at 16'hFFFF. Only reset clears it.

## Timing
- All stored fields and `bubble_cnt` update on the `clk` rising edge.
- `rst_n` low clears every stored field and `bubble_cnt` to 0 immediately, without waiting for a clock edge. All outputs therefore read 0 during reset, including `load_use_hazard`.
- Reset taken mid-stall or mid-hazard discards the held instruction.
- Latency: decode inputs captured at edge N appear on the registered outputs after edge N.
- `alu_a`, `alu_b`, `ex_store_data` and `load_use_hazard` are combinational from the stored fields and same-cycle inputs. No extra cycle is added.
- A load-use hazard produces exactly one bubble while `stall` stays low. At the next edge the load has left EX, the hazard deasserts, and the held instruction is captured. Forwarding then comes from MEM/WB (the load result then sits in MEM/WB).
- A hazard with `stall` high holds the stage. The bubble is inserted on the first non-stalled edge.

## Configuration
- Macro: `ID_EX_FORWARD_EN`.
- Defined: forwarding operates as described in Operation.
- Undefined:
  - The forwarding muxes are removed. `alu_a`, `alu_b` and `ex_store_data` use only the stored data. The `exmem_result` and `memwb_result` data inputs are unused.
  - `load_use_hazard` widens to any RAW dependence. It asserts on an EX-slot writer (`ex_valid` & `ex_reg_write`), or on `exmem_reg_write`, whose nonzero destination equals `id_rs` or `id_rt`.
  - MEM/WB distance dependences are resolved by the register file's write-first read.

## Test plan
- Reset: hold `rst_n`=0 mid-capture → every output reads 0 asynchronously. After release with `id_valid`=0, `ex_valid` stays 0.
- Capture with forwarding: `id_rs`=3, `id_rs_data`=5, `exmem_reg_write`=1, `exmem_rd`=3, `exmem_result`=100, `memwb_rd`=3, `memwb_result`=7 → `alu_a`=100. Set `exmem_rd`=0 → `alu_a`=7.
- Immediate select: `id_alu_src`=1, `id_imm`=-4 (0xFFFFFFFC), rt forwarded to 9 → `alu_b`=0xFFFFFFFC and `ex_store_data`=9.
- Load-use: lw r2 in EX, next instruction uses `id_rt`=2 → `load_use_hazard`=1, one bubble inserted (`ex_valid`=0), `bubble_cnt`=1. The following edge captures the instruction.
- Stall and flush together: `stall`=1 and `flush`=1 on a valid entry → bubble inserted. With `stall`=1 alone for 3 cycles, all outputs are unchanged.
- Saturation: force 65536 hazard bubbles → `bubble_cnt` stops at 0xFFFF.
